length_generation_n: RTL and testbench

LENGTH_GENERATION_N -- requirements
Module: length_generation_n

---
 rtl/length_generation_n.sv | 191 +++++++++++++++++++
 tb/tb_length_generation_n.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/length_generation_n.sv
// Per-word compressed length encoder with cache-line packing,
// block size limiting and flush padding.
module length_generation_n #(
    parameter int NUM_WORDS   = 2,
    parameter int WORD_SIZE   = 32,
    parameter int CACHE_LINE  = 128,
    parameter int BLOCK_LIMIT = 256,
    localparam int LW = $clog2(WORD_SIZE + 3),
    localparam int TW = $clog2(NUM_WORDS * (WORD_SIZE + 2) + 1),
    localparam int FW = $clog2(CACHE_LINE + 1),
    localparam int BW = $clog2(BLOCK_LIMIT + NUM_WORDS * (WORD_SIZE + 2) + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [NUM_WORDS-1:0]    i_type_matched1,
    input  logic [NUM_WORDS-1:0]    i_match_s,
    input  logic [2*NUM_WORDS-1:0]  i_type_matched2,
    input  logic                    i_last,
    input  logic                    i_flush,
    output logic [3*NUM_WORDS-1:0]  o_encoded,
    output logic [LW*NUM_WORDS-1:0] o_length,
    output logic [TW-1:0]           o_total_length,
    output logic                    o_valid,
    output logic [FW-1:0]           o_shift_amount,
    output logic                    o_store_flag,
    output logic                    o_output_flag,
    output logic                    o_fill_flag,
    output logic                    o_stop_flag,
    output logic                    o_send_back,
    output logic [FW-1:0]           o_fill_level
);

    localparam int SW = FW + 1;
    localparam logic [1:0] ACCUM = 2'd0;
    localparam logic [1:0] FLUSH = 2'd1;
    localparam logic [1:0] ABORT = 2'd2;

    logic [1:0]    state;
    logic          rst_done;
    logic [FW-1:0] fill;
    logic [FW-1:0] snap;
    logic [BW-1:0] block_count;

    logic [2:0]    code [NUM_WORDS];
    logic [LW-1:0] len  [NUM_WORDS];
    logic [TW-1:0] total;

    always_comb begin
        total     = '0;
        o_encoded = '0;
        o_length  = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            code[k] = 3'b110;
            len[k]  = LW'(WORD_SIZE + 2);
            if (i_type_matched1[k]) begin
                code[k] = 3'b000;
                len[k]  = LW'(2);
            end else if (i_match_s[k]) begin
                code[k] = 3'b001;
                len[k]  = LW'(6);
            end else begin
                unique case (i_type_matched2[2*k +: 2])
                    2'b11: begin code[k] = 3'b011; len[k] = LW'(16); end
                    2'b10: begin code[k] = 3'b100; len[k] = LW'(24); end
                    2'b01: begin code[k] = 3'b101; len[k] = LW'(12); end
                    default: begin
                        code[k] = 3'b110;
                        len[k]  = LW'(WORD_SIZE + 2);
                    end
                endcase
            end
            o_encoded[3*k +: 3] = code[k];
            o_length[LW*k +: LW] = len[k];
            total = total + TW'(len[k]);
        end
    end

    assign o_total_length = total;
    assign o_fill_level   = fill;
    assign o_ready        = rst_done & (state != FLUSH);

    logic          accept;
    logic [BW-1:0] blk_sum;
    logic          over;
    logic [SW-1:0] s_sum;
    logic [FW-1:0] snap_eff;
    logic          acc_store;
    logic          acc_out;
    logic [FW-1:0] acc_shift;
    logic [FW-1:0] acc_fill;
    logic [FW-1:0] post_fill;
    logic          go_abort;
    logic          go_flush;

    assign accept   = i_valid & o_ready;
    assign blk_sum  = block_count + BW'(total);
    assign over     = blk_sum > BW'(BLOCK_LIMIT);
    assign s_sum    = SW'(fill) + SW'(total);
    assign snap_eff = (block_count == '0) ? fill : snap;

    always_comb begin
        acc_store = 1'b0;
        acc_out   = 1'b0;
        acc_shift = '0;
        acc_fill  = fill;
        if (over) begin
            acc_fill = snap_eff;
        end else if (s_sum < SW'(CACHE_LINE)) begin
            acc_store = 1'b1;
            acc_shift = FW'(total);
            acc_fill  = FW'(s_sum);
        end else if (s_sum == SW'(CACHE_LINE)) begin
            acc_out   = 1'b1;
            acc_shift = FW'(total);
            acc_fill  = '0;
        end else begin
            // spill: the remainder opens the next line
            acc_out   = 1'b1;
            acc_shift = FW'(CACHE_LINE) - fill;
            acc_fill  = FW'(s_sum - SW'(CACHE_LINE));
        end
    end

    assign post_fill = accept ? acc_fill : fill;
    assign go_abort  = accept & over & ~i_last;
    assign go_flush  = i_flush & ~go_abort & (post_fill != '0);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state          <= ACCUM;
            rst_done       <= 1'b0;
            fill           <= '0;
            snap           <= '0;
            block_count    <= '0;
            o_valid        <= 1'b0;
            o_shift_amount <= '0;
            o_store_flag   <= 1'b0;
            o_output_flag  <= 1'b0;
            o_fill_flag    <= 1'b0;
            o_stop_flag    <= 1'b0;
            o_send_back    <= 1'b0;
        end else begin
            rst_done       <= 1'b1;
            o_valid        <= 1'b0;
            o_shift_amount <= '0;
            o_store_flag   <= 1'b0;
            o_output_flag  <= 1'b0;
            o_fill_flag    <= 1'b0;
            o_stop_flag    <= 1'b0;
            unique case (state)
                ACCUM: begin
                    if (accept) begin
                        o_valid        <= 1'b1;
                        o_store_flag   <= acc_store;
                        o_output_flag  <= acc_out;
                        o_shift_amount <= acc_shift;
                        o_stop_flag    <= over;
                        o_send_back    <= over;
                        block_count    <= i_last ? '0 : blk_sum;
                        if (block_count == '0) snap <= fill;
                    end
                    fill <= post_fill;
                    if (go_abort) state <= ABORT;
                    else if (go_flush) state <= FLUSH;
                end
                ABORT: begin
                    if (accept) begin
                        o_valid <= 1'b1;
                        if (i_last) begin
                            state       <= ACCUM;
                            o_send_back <= 1'b0;
                            block_count <= '0;
                        end
                    end
                end
                FLUSH: begin
                    o_valid        <= 1'b1;
                    o_fill_flag    <= 1'b1;
                    o_output_flag  <= 1'b1;
                    o_shift_amount <= FW'(CACHE_LINE) - fill;
                    fill           <= '0;
                    state          <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_length_generation_n.sv
// Directed bench for length_generation_n: encoder vector table
// plus hand-written packing, flush, abort and reset sequences.
module tb_length_generation_n;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [1:0]  tm1 = '0;
    logic [1:0]  ms = '0;
    logic [3:0]  tm2 = '0;
    logic        i_last = 1'b0;
    logic        i_flush = 1'b0;
    logic [5:0]  o_encoded;
    logic [11:0] o_length;
    logic [6:0]  o_total_length;
    logic        o_valid;
    logic [7:0]  o_shift_amount;
    logic        o_store_flag;
    logic        o_output_flag;
    logic        o_fill_flag;
    logic        o_stop_flag;
    logic        o_send_back;
    logic [7:0]  o_fill_level;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    length_generation_n dut (
        .i_clk(clk),
        .i_reset(rst_n),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_type_matched1(tm1),
        .i_match_s(ms),
        .i_type_matched2(tm2),
        .i_last(i_last),
        .i_flush(i_flush),
        .o_encoded(o_encoded),
        .o_length(o_length),
        .o_total_length(o_total_length),
        .o_valid(o_valid),
        .o_shift_amount(o_shift_amount),
        .o_store_flag(o_store_flag),
        .o_output_flag(o_output_flag),
        .o_fill_flag(o_fill_flag),
        .o_stop_flag(o_stop_flag),
        .o_send_back(o_send_back),
        .o_fill_level(o_fill_level)
    );

    typedef struct {
        logic [1:0] t1;
        logic [1:0] m;
        logic [3:0] t2;
        logic [5:0] enc;
        int         len0;
        int         len1;
        int         tot;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic [1:0] t1,
                        input logic [1:0] m, input logic [3:0] t2,
                        input logic l, input logic f);
        i_valid = v;
        tm1 = t1;
        ms = m;
        tm2 = t2;
        i_last = l;
        i_flush = f;
        tick();
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_last = 1'b0;
    endtask

    task automatic unc(input logic l);
        beat(1'b1, 2'b00, 2'b00, 4'b0000, l, 1'b0);
    endtask

    task automatic zero4(input logic l);
        beat(1'b1, 2'b11, 2'b00, 4'b0000, l, 1'b0);
    endtask

    task automatic flags(input string tag, input int st, input int ou,
                         input int sh, input int fl);
        chk({tag, " valid"}, o_valid, 1);
        chk({tag, " store"}, o_store_flag, st);
        chk({tag, " output"}, o_output_flag, ou);
        chk({tag, " shift"}, o_shift_amount, sh);
        chk({tag, " fill"}, o_fill_level, fl);
    endtask

    initial begin
        vt[0] = '{2'b11, 2'b00, 4'b0000, 6'o00, 2, 2, 4};
        vt[1] = '{2'b00, 2'b00, 4'b0000, 6'o66, 34, 34, 68};
        vt[2] = '{2'b01, 2'b11, 4'b0000, 6'o10, 2, 6, 8};
        vt[3] = '{2'b00, 2'b00, 4'b1110, 6'o34, 24, 16, 40};
        vt[4] = '{2'b00, 2'b00, 4'b0100, 6'o56, 34, 12, 46};
        vt[5] = '{2'b01, 2'b01, 4'b0100, 6'o50, 2, 12, 14};

        #12;
        chk("rst ready", o_ready, 0);
        chk("rst valid", o_valid, 0);
        chk("rst fill", o_fill_level, 0);

        for (int i = 0; i < 6; i++) begin
            tm1 = vt[i].t1;
            ms = vt[i].m;
            tm2 = vt[i].t2;
            #1;
            chk($sformatf("v%0d enc", i), o_encoded, vt[i].enc);
            chk($sformatf("v%0d len0", i), o_length[5:0], vt[i].len0);
            chk($sformatf("v%0d len1", i), o_length[11:6], vt[i].len1);
            chk($sformatf("v%0d total", i), o_total_length, vt[i].tot);
        end

        tick();
        rst_n = 1'b1;
        #1;
        chk("pre-edge ready", o_ready, 0);
        tick();
        chk("post-rst ready", o_ready, 1);

        zero4(1'b1);
        flags("zero", 1, 0, 4, 4);
        tick();
        chk("idle valid", o_valid, 0);
        chk("idle store", o_store_flag, 0);
        beat(1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b1);
        chk("fl4 ready", o_ready, 0);
        tick();
        chk("fl4 fillflag", o_fill_flag, 1);
        flags("fl4", 0, 1, 124, 0);

        unc(1'b0);
        flags("unc1", 1, 0, 68, 68);
        unc(1'b1);
        flags("unc2", 0, 1, 60, 8);

        beat(1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b1);
        chk("fl8 ready", o_ready, 0);
        chk("fl8 busyvalid", o_valid, 0);
        tick();
        chk("fl8 fillflag", o_fill_flag, 1);
        flags("fl8", 0, 1, 120, 0);
        chk("fl8 ready after", o_ready, 1);

        zero4(1'b1);
        unc(1'b0);
        flags("b1", 1, 0, 68, 72);
        unc(1'b0);
        flags("b2", 0, 1, 56, 12);
        unc(1'b0);
        flags("b3", 1, 0, 68, 80);
        unc(1'b1);
        chk("b4 stop", o_stop_flag, 1);
        chk("b4 sendback", o_send_back, 1);
        chk("b4 store", o_store_flag, 0);
        chk("b4 output", o_output_flag, 0);
        chk("b4 fill", o_fill_level, 4);
        chk("b4 ready", o_ready, 1);
        tick();
        chk("b4 stop pulse", o_stop_flag, 0);
        zero4(1'b1);
        flags("after stop", 1, 0, 4, 8);
        chk("after stop sb", o_send_back, 0);

        beat(1'b1, 2'b01, 2'b01, 4'b0100, 1'b1, 1'b1);
        flags("mix", 1, 0, 14, 22);
        chk("mix ready", o_ready, 0);
        tick();
        chk("mix fillflag", o_fill_flag, 1);
        flags("mixfl", 0, 1, 106, 0);

        beat(1'b1, 2'b00, 2'b00, 4'b1110, 1'b1, 1'b0);
        flags("f40", 1, 0, 40, 40);
        unc(1'b0);
        flags("a1", 1, 0, 68, 108);
        unc(1'b0);
        flags("a2", 0, 1, 20, 48);
        unc(1'b0);
        flags("a3", 1, 0, 68, 116);
        unc(1'b0);
        chk("a4 stop", o_stop_flag, 1);
        chk("a4 sendback", o_send_back, 1);
        chk("a4 fill", o_fill_level, 40);
        unc(1'b0);
        chk("abort store", o_store_flag, 0);
        chk("abort fill", o_fill_level, 40);
        chk("abort sb", o_send_back, 1);

        rst_n = 1'b0;
        #1;
        chk("mid rst valid", o_valid, 0);
        chk("mid rst sb", o_send_back, 0);
        chk("mid rst fill", o_fill_level, 0);
        chk("mid rst ready", o_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel ready", o_ready, 1);
        chk("rel fill", o_fill_level, 0);

        unc(1'b0);
        unc(1'b0);
        unc(1'b0);
        unc(1'b0);
        chk("c4 stop", o_stop_flag, 1);
        chk("c4 fill", o_fill_level, 0);
        beat(1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b1);
        chk("abort flush ready", o_ready, 1);
        tick();
        chk("abort flush ff", o_fill_flag, 0);
        unc(1'b0);
        chk("c5 sb", o_send_back, 1);
        chk("c5 store", o_store_flag, 0);
        unc(1'b1);
        chk("c6 sb", o_send_back, 0);
        chk("c6 output", o_output_flag, 0);
        zero4(1'b1);
        flags("c7", 1, 0, 4, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
